muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the EXE stage, replacing the fixed 32-bit single-mode HI/LO path with a WIDTH-parametrised, signed/unsigned, cancellable engine. Accepts one operation per handshake, runs a shift-add multiplier or a restoring divider over multiple cycles, and presents a {hi, lo} result with a one-cycle completion pulse. EXE holds `EXE_over` low until `md_over` arrives.

## Interface
- `WIDTH`, 32: operand width; must be ≥4 and even.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `md_start`  in  1  request; accepted only when `md_busy`=0.
- `md_op`  in  2  01 = multiply, 10 = divide; 00/11 = no-op, `md_start` ignored.
- `md_signed`  in  1  1 = two's-complement operands, 0 = unsigned.
- `md_a`, `md_b`  in  WIDTH  multiplicand/dividend and multiplier/divisor.
- `md_cancel`  in  1  flush; aborts any in-flight op.
- `md_busy`  out  1  high from the cycle after accept through the DONE cycle.
- `md_over`  out  1  one-cycle completion pulse.
- `md_hi`, `md_lo`  out  WIDTH  product high/low, or remainder/quotient.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: on `md_start` with valid op and no `md_cancel`, latch the operands' absolute values and the result sign. Clear the counter and go to MUL or DIV.
- Divisor = 0: go directly to DONE with quotient = all-ones and remainder = `md_a` (raw).
- MUL: one shift-add step per cycle, WIDTH steps. At count WIDTH-1 → DONE.
- DIV: one restoring step per cycle, WIDTH steps. At count WIDTH-1 → DONE.
- DONE: apply sign fix-up, load `md_hi`/`md_lo`, assert `md_over` for one cycle, then → IDLE.
- Signed multiply: negate the 2·WIDTH product when operand signs differ.
- Signed divide: quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
- Signed divide MIN / −1: quotient = MIN, remainder = 0, with no trap.
- `md_cancel` in any state → IDLE next cycle. No `md_over`; `md_hi`/`md_lo` keep their previous values.
- `md_cancel` and `md_start` in the same IDLE cycle: cancel wins and nothing is accepted.
- `md_start` while busy: ignored, with no queueing.
- `md_hi`/`md_lo` change only in DONE and hold until the next DONE.
- Counter width is $clog2(WIDTH) bits.

## Timing
- Reset values: state = IDLE; `md_busy`=0, `md_over`=0, `md_hi`=0, `md_lo`=0; counter and internal registers = 0.
- Accept at edge 0.
  - Iterative op: `md_over` is high during cycle WIDTH+1 (33 for the default).
  - Divide-by-zero: `md_over` is high during cycle 1.
- `md_busy` is low in the cycle after `md_over`, so a back-to-back `md_start` is accepted there. Issue interval = WIDTH+2.
- Reset asserted mid-op: all state is cleared immediately, with no `md_over`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - Multiply is a single combinational WIDTH×WIDTH product registered on accept.
  - State goes IDLE → DONE, so `md_over` is high in cycle 1.
  - The MUL state is not synthesised.
- Not defined: iterative multiply only, as described above. Divide is unaffected in both cases.

## Structure
- Package `muldiv_pkg`: the `md_op` encodings (MD_OP_MUL, MD_OP_DIV) and the state enum.
- Sub-module `muldiv_sign_fix`: combinational absolute-value on input and conditional negation on output, parametrised by WIDTH. It is instantiated once for the operands and once for the result.

## Test plan
- Unsigned mul, 290 × 21, WIDTH=32 → `md_over` at cycle 33; hi=0, lo=6090.
- Unsigned mul, 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed mul, −1 × −1 → hi=0, lo=1.
- Signed div, 290 / 21 → lo=13, hi=17.
- Signed div, −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero, 5 / 0 unsigned → `md_over` at cycle 1; lo=0xFFFFFFFF, hi=5.
- Signed div, 0x80000000 / −1 → lo=0x80000000, hi=0.
- `md_cancel` at cycle 10 of a multiply → `md_busy` low at cycle 11, no `md_over`, hi/lo unchanged.
- `reset` pulsed at cycle 5 of a divide → all outputs 0 and state IDLE.
- A following `md_start` is accepted normally after both the cancel and the reset cases.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes
// and the controller state type.
package muldiv_pkg;

  localparam logic [1:0] MD_OP_MUL = 2'b01;
  localparam logic [1:0] MD_OP_DIV = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation of a {hi, lo} pair, either per half
// (operand magnitudes, quotient/remainder) or as one 2*WIDTH value (product).
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  input  logic             wide_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] pair_neg;
  logic [WIDTH-1:0]   hi_neg;
  logic [WIDTH-1:0]   lo_neg;

  assign pair_neg = {(2*WIDTH){1'b0}} - {hi_i, lo_i};
  assign hi_neg   = {WIDTH{1'b0}} - hi_i;
  assign lo_neg   = {WIDTH{1'b0}} - lo_i;

  // In wide mode neg_hi_i alone selects negation of the whole pair.
  always_comb begin
    if (wide_i) begin
      {hi_o, lo_o} = neg_hi_i ? pair_neg : {hi_i, lo_i};
    end else begin
      hi_o = neg_hi_i ? hi_neg : hi_i;
      lo_o = neg_lo_i ? lo_neg : lo_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring) unit.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic             md_signed,
  input  logic [WIDTH-1:0] md_a,
  input  logic [WIDTH-1:0] md_b,
  input  logic             md_cancel,
  output logic             md_busy,
  output logic             md_over,
  output logic [WIDTH-1:0] md_hi,
  output logic [WIDTH-1:0] md_lo
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0] md_hi_q, md_hi_d;
  logic [WIDTH-1:0] md_lo_q, md_lo_d;
  logic             md_over_q, md_over_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             accept, last;

  logic [WIDTH-1:0] res_hi_raw, res_lo_raw, res_hi, res_lo;
  logic             res_neg_hi, res_neg_lo, res_wide, load_res;

  assign sign_a = md_signed & md_a[WIDTH-1];
  assign sign_b = md_signed & md_b[WIDTH-1];
  assign accept = (state_q == ST_IDLE) && md_start && !md_cancel &&
                  ((md_op == MD_OP_MUL) || (md_op == MD_OP_DIV));
  assign last   = (cnt_q == CNT_LAST);

  // Operand magnitudes: both halves negated independently.
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_opnd_fix (
    .hi_i     (md_a),
    .lo_i     (md_b),
    .neg_hi_i (sign_a),
    .neg_lo_i (sign_b),
    .wide_i   (1'b0),
    .hi_o     (abs_a),
    .lo_o     (abs_b)
  );

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_res_fix (
    .hi_i     (res_hi_raw),
    .lo_i     (res_lo_raw),
    .neg_hi_i (res_neg_hi),
    .neg_lo_i (res_neg_lo),
    .wide_i   (res_wide),
    .hi_o     (res_hi),
    .lo_o     (res_lo)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`else
  // Shift-add step: acc_lo holds the unconsumed multiplier bits.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`endif

  // Restoring step: the partial remainder never exceeds the divisor, so the
  // difference fits in WIDTH bits whenever it is kept.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_rem, div_quo;
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_quo   = {acc_lo_q[WIDTH-2:0], div_ge};

  // Result source select; the fixed-up value is loaded on entry to DONE.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    res_hi_raw = '0;
    res_lo_raw = '0;
    res_neg_hi = 1'b0;
    res_neg_lo = 1'b0;
    res_wide   = 1'b0;
    load_res   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (md_op == MD_OP_DIV) && (md_b == '0)) begin
          res_hi_raw = md_a;
          res_lo_raw = '1;
          load_res   = 1'b1;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (accept && (md_op == MD_OP_MUL)) begin
          {res_hi_raw, res_lo_raw} = fast_prod;
          res_wide   = 1'b1;
          res_neg_hi = sign_a ^ sign_b;
          load_res   = 1'b1;
        end
`endif
      end
`ifndef MULDIV_FAST_MUL_EN
      ST_MUL: begin
        if (last) begin
          res_hi_raw = mul_hi;
          res_lo_raw = mul_lo;
          res_wide   = 1'b1;
          res_neg_hi = neg_hi_q;
          load_res   = 1'b1;
        end
      end
`endif
      ST_DIV: begin
        if (last) begin
          res_hi_raw = div_rem;
          res_lo_raw = div_quo;
          res_neg_hi = neg_hi_q;
          res_neg_lo = neg_lo_q;
          load_res   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    neg_hi_d  = neg_hi_q;
    neg_lo_d  = neg_lo_q;
    md_over_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (load_res) begin
            state_d = ST_DONE;
          end else if (md_op == MD_OP_DIV) begin
            opnd_d   = abs_b;
            acc_hi_d = '0;
            acc_lo_d = abs_a;
            neg_hi_d = sign_a;
            neg_lo_d = sign_a ^ sign_b;
            state_d  = ST_DIV;
          end
`ifndef MULDIV_FAST_MUL_EN
          else begin
            opnd_d   = abs_a;
            acc_hi_d = '0;
            acc_lo_d = abs_b;
            neg_hi_d = sign_a ^ sign_b;
            state_d  = ST_MUL;
          end
`endif
        end
      end
`ifndef MULDIV_FAST_MUL_EN
      ST_MUL: begin
        acc_hi_d = mul_hi;
        acc_lo_d = mul_lo;
        cnt_d    = cnt_q + CNT_ONE;
        if (last) state_d = ST_DONE;
      end
`endif
      ST_DIV: begin
        acc_hi_d = div_rem;
        acc_lo_d = div_quo;
        cnt_d    = cnt_q + CNT_ONE;
        if (last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    md_over_d = load_res;
    if (md_cancel) begin
      state_d   = ST_IDLE;
      md_over_d = 1'b0;
    end
  end

  assign md_hi_d = md_over_d ? res_hi : md_hi_q;
  assign md_lo_d = md_over_d ? res_lo : md_lo_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      neg_hi_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      md_hi_q   <= '0;
      md_lo_q   <= '0;
      md_over_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      neg_hi_q  <= neg_hi_d;
      neg_lo_q  <= neg_lo_d;
      md_hi_q   <= md_hi_d;
      md_lo_q   <= md_lo_d;
      md_over_q <= md_over_d;
    end
  end

  assign md_busy = (state_q != ST_IDLE);
  assign md_over = md_over_q;
  assign md_hi   = md_hi_q;
  assign md_lo   = md_lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table issued back-to-back, then
// cancel, cancel-vs-start, start-while-busy and mid-op reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int TIMEOUT = 60;
  localparam int ITER_LAT = W + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         md_start = 1'b0;
  logic [1:0]   md_op = 2'b00;
  logic         md_signed = 1'b0;
  logic [W-1:0] md_a = '0;
  logic [W-1:0] md_b = '0;
  logic         md_cancel = 1'b0;
  logic         md_busy, md_over;
  logic [W-1:0] md_hi, md_lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_signed (md_signed),
    .md_a      (md_a),
    .md_b      (md_b),
    .md_cancel (md_cancel),
    .md_busy   (md_busy),
    .md_over   (md_over),
    .md_hi     (md_hi),
    .md_lo     (md_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting edge (edge 0).
  task automatic issue(input logic [1:0] op, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    md_start  = 1'b1;
    md_op     = op;
    md_signed = sgn;
    md_a      = a;
    md_b      = b;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    md_op    = 2'b00;
  endtask

  // Cycle n is sampled at the n-th negedge after the call.
  task automatic wait_over(output int lat, output logic [W-1:0] hi, output logic [W-1:0] lo);
    lat = -1;
    hi  = '0;
    lo  = '0;
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(negedge clk);
      if (md_over) begin
        lat = n;
        hi  = md_hi;
        lo  = md_lo;
        break;
      end
    end
  endtask

  task automatic watch_no_over(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (md_over) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, seen;
    logic [W-1:0] hi, lo;

    vecs[0]  = '{MD_OP_MUL, 1'b0, 32'd290,       32'd21,        MUL_LAT,  32'h0,        32'd6090};
    vecs[1]  = '{MD_OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,  32'hFFFF_FFFE, 32'h1};
    vecs[2]  = '{MD_OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,  32'h0,        32'h1};
    vecs[3]  = '{MD_OP_DIV, 1'b1, 32'd290,       32'd21,        ITER_LAT, 32'd17,       32'd13};
    vecs[4]  = '{MD_OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2,         ITER_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5]  = '{MD_OP_DIV, 1'b0, 32'd5,         32'd0,         1,        32'd5,        32'hFFFF_FFFF};
    vecs[6]  = '{MD_OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, ITER_LAT, 32'h0,        32'h8000_0000};
    vecs[7]  = '{MD_OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5,         MUL_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[8]  = '{MD_OP_DIV, 1'b0, 32'hFFFF_FFFF, 32'd16,        ITER_LAT, 32'hF,        32'h0FFF_FFFF};
    vecs[9]  = '{MD_OP_DIV, 1'b1, 32'd7,         32'hFFFF_FFFE, ITER_LAT, 32'd1,        32'hFFFF_FFFD};
    vecs[10] = '{MD_OP_MUL, 1'b0, 32'h1234_5678, 32'h10,        MUL_LAT,  32'h1,        32'h2345_6780};
    vecs[11] = '{MD_OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0,         1,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[12] = '{MD_OP_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, MUL_LAT,  32'h4000_0000, 32'h0};
    vecs[13] = '{MD_OP_MUL, 1'b0, 32'h8000_0000, 32'd2,         MUL_LAT,  32'h1,        32'h0};

    // Reset state
    #12;
    check("rst_busy", {63'd0, md_busy}, 64'd0);
    check("rst_over", {63'd0, md_over}, 64'd0);
    check("rst_hi", {32'd0, md_hi}, 64'd0);
    check("rst_lo", {32'd0, md_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Table: each op is issued in the cycle right after the previous md_over.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_over(lat, hi, lo);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
      @(negedge clk);
      check($sformatf("v%0d_over_pulse", i), {63'd0, md_over}, 64'd0);
      check($sformatf("v%0d_idle", i), {63'd0, md_busy}, 64'd0);
    end

    // Start while busy is ignored: divide keeps running, intruder dropped.
    issue(MD_OP_DIV, 1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    check("busy_mid_div", {63'd0, md_busy}, 64'd1);
    issue(MD_OP_DIV, 1'b0, 32'd9, 32'd0);
    wait_over(lat, hi, lo);
    check("busy_ign_lat", 64'(lat), 64'(ITER_LAT - 4));
    check("busy_ign_hi", {32'd0, hi}, 64'd2);
    check("busy_ign_lo", {32'd0, lo}, 64'd14);
    @(negedge clk);

    // Cancel during cycle 10 of a long operation.
`ifdef MULDIV_FAST_MUL_EN
    issue(MD_OP_DIV, 1'b0, 32'd290, 32'd21);
`else
    issue(MD_OP_MUL, 1'b0, 32'd290, 32'd21);
`endif
    repeat (10) @(negedge clk);
    check("cancel_busy_before", {63'd0, md_busy}, 64'd1);
    md_cancel = 1'b1;
    @(posedge clk);
    #1;
    md_cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy_after", {63'd0, md_busy}, 64'd0);
    watch_no_over(40, seen);
    check("cancel_no_over", 64'(seen), 64'd0);
    check("cancel_hi_hold", {32'd0, md_hi}, 64'd2);
    check("cancel_lo_hold", {32'd0, md_lo}, 64'd14);
    issue(MD_OP_MUL, 1'b0, 32'd3, 32'd4);
    wait_over(lat, hi, lo);
    check("post_cancel_lat", 64'(lat), 64'(MUL_LAT));
    check("post_cancel_lo", {32'd0, lo}, 64'd12);
    @(negedge clk);

    // Cancel and start together in IDLE: nothing accepted.
    md_cancel = 1'b1;
    issue(MD_OP_DIV, 1'b0, 32'd5, 32'd0);
    md_cancel = 1'b0;
    @(negedge clk);
    check("cancel_start_busy", {63'd0, md_busy}, 64'd0);
    watch_no_over(5, seen);
    check("cancel_start_no_over", 64'(seen), 64'd0);
    check("cancel_start_lo", {32'd0, md_lo}, 64'd12);

    // Reset pulsed in cycle 5 of a divide.
    issue(MD_OP_DIV, 1'b1, 32'd290, 32'd21);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, md_busy}, 64'd0);
    check("mid_rst_over", {63'd0, md_over}, 64'd0);
    check("mid_rst_hi", {32'd0, md_hi}, 64'd0);
    check("mid_rst_lo", {32'd0, md_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    watch_no_over(40, seen);
    check("mid_rst_no_over", 64'(seen), 64'd0);
    issue(MD_OP_DIV, 1'b0, 32'd1000, 32'd3);
    wait_over(lat, hi, lo);
    check("post_rst_lat", 64'(lat), 64'(ITER_LAT));
    check("post_rst_hi", {32'd0, hi}, 64'd1);
    check("post_rst_lo", {32'd0, lo}, 64'd333);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
